redun_word_serializer: RTL

- Sits directly downstream of the column squarer.
- Captures one full squarer result: 2*NUM_ELEMENTS redundant words, each WORD_LEN+1 bits wide.
- Resolves the inter-word carries serially, one word per cycle, and streams canonical WORD_LEN-bit words LSW-first over a valid/ready interface.
- Used to export a non-redundant square to the host/result FIFO.

---
 rtl/redun_word_serializer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/redun_word_serializer.sv
// redun_word_serializer
//   Captures one complete column-squarer result (2*NUM_ELEMENTS redundant
//   words of WORD_LEN+1 bits, index 0 least significant), then resolves the
//   inter-word carries one word per cycle. Canonical WORD_LEN-bit words are
//   streamed LSW-first over valid/ready. On the last word the final carry
//   (0..2) is reported on out_carry.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     in_words holds a complete result
//   in_ready     block can capture in_words this cycle
//   in_words     redundant result, [2*NUM_ELEMENTS-1:0][IN_WORD_LEN-1:0]
//   out_valid    out_word valid
//   out_ready    downstream accepts out_word
//   out_word     canonical word
//   out_last     marks word index 2*NUM_ELEMENTS-1
//   out_carry    final carry out; nonzero only with out_last
module redun_word_serializer #(
  parameter int NUM_ELEMENTS = 33,
  parameter int WORD_LEN     = 16,
  parameter int IN_WORD_LEN  = WORD_LEN + 1,
  parameter int CNT_BITS     = $clog2(2 * NUM_ELEMENTS)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [2*NUM_ELEMENTS-1:0][IN_WORD_LEN-1:0]   in_words,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [WORD_LEN-1:0]                          out_word,
  output logic                                         out_last,
  output logic [1:0]                                   out_carry
);

  localparam int NUM_WORDS = 2 * NUM_ELEMENTS;
  // buf[idx] + carry: one bit wider than a redundant word, so the top two
  // bits are the carry into the next word (at most 2).
  localparam int SUM_W     = IN_WORD_LEN + 1;
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic capture;   // load a new result this cycle
  logic advance;   // step to the next word of the current result
  logic finish;    // last word accepted, nothing new to capture

  logic [NUM_WORDS-1:0][IN_WORD_LEN-1:0] buf_q;
  logic [CNT_BITS-1:0]                   idx_q;
  logic [CNT_BITS-1:0]                   idx_nxt;
  // Holds buf[idx] + carry for the word being presented. The incoming carry
  // is folded into this register, so the low bits drive out_word straight
  // from flops and the high bits are the carry for the following word.
  logic [SUM_W-1:0]                      sum_q;
  logic [SUM_W-1:0]                      sum_nxt;
  logic [1:0]                            carry_nxt;
  logic                                  last_nxt;

  logic       out_valid_q;
  logic       out_last_q;
  logic [1:0] out_carry_q;

  assign out_valid = out_valid_q;
  assign out_word  = sum_q[WORD_LEN-1:0];
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    capture  = 1'b0;
    advance  = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            // Last beat leaving: open the input so the next result can be
            // taken on the same edge without an idle cycle.
            in_ready = 1'b1;
            if (in_valid) capture = 1'b1;
            else begin
              finish  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------- carry chain
  always_comb begin
    carry_nxt = sum_q[SUM_W-1:WORD_LEN];
    // Clamp so the buffer is never indexed past its end; the wrapped value
    // is only formed on the last word, where advance is never asserted.
    idx_nxt   = (idx_q == LAST_IDX) ? '0 : idx_q + CNT_BITS'(1);
    sum_nxt   = SUM_W'(buf_q[idx_nxt]) + SUM_W'(carry_nxt);
    last_nxt  = (idx_nxt == LAST_IDX);
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_carry_q <= 2'b0;
    end else if (capture) begin
      // Word 0 starts with zero carry. A result always has at least two
      // words, so word 0 is never the last one.
      buf_q       <= in_words;
      idx_q       <= '0;
      sum_q       <= SUM_W'(in_words[0]);
      out_valid_q <= 1'b1;
      out_last_q  <= 1'b0;
      out_carry_q <= 2'b0;
    end else if (advance) begin
      idx_q       <= idx_nxt;
      sum_q       <= sum_nxt;
      out_last_q  <= last_nxt;
      out_carry_q <= last_nxt ? sum_nxt[SUM_W-1:WORD_LEN] : 2'b0;
    end else if (finish) begin
      idx_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_carry_q <= 2'b0;
    end
  end

endmodule
